message_scroller: RTL and testbench
===================================

// Module: message_scroller
// PURPOSE
//  Generates the six ASCII characters (char5 = leftmost HEX5 .. char0 = HEX0) driven into the
//  seven-segment decoder. Holds a fixed message table for the vending-machine UI. Messages of
//  6 chars or fewer are shown static and left-justified; longer messages scroll left at SCROLL_HZ.
//  Message 7 embeds a 3-digit BCD price. Sits between the vending FSM and the segment decoder.
// PARAMETERS
//  CLK_HZ     50_000_000  input clock frequency
//  SCROLL_HZ  4           scroll step rate; SCROLL_DIV = CLK_HZ/SCROLL_HZ cycles per step (must be >= 2)
//  MAX_LEN    16          longest table entry; sizes index/pos registers ($clog2(MAX_LEN+1) bits)
// PORTS
//  clock      in   1   system clock, all state updates on rising edge
//  reset_n    in   1   asynchronous, active-low reset
//  msg_sel    in   3   message ID, sampled only when msg_load=1
//  msg_load   in   1   1-cycle request: start showing msg_sel (restarts any message in progress)
//  price_bcd  in   12  3 BCD digits for msg 7, sampled with msg_load; nibble >9 renders as " "
//  char0..5   out  8   ASCII per digit, registered; 8'h20 = blank
//  busy       out  1   1 while a message is displayed/scrolling
//  done       out  1   1-cycle pulse at end of one complete pass
// BEHAVIOUR
//  - Reset (async, any time incl. mid-scroll): char0..5 = 8'h20, busy=0, done=0, state IDLE,
//    pos=0, tick counter=0. No pulse on done from reset.
//  - Table: 0 "SELECT", 1 "INSERT COIN", 2 "PAID", 3 "THANK YOU", 4 "SOLD OUT", 5 "CANCEL",
//    6 "ERROR", 7 "CASH " + 3 price digits (8 chars; digit = 8'h30 + nibble).
//  - States: IDLE -> (msg_load) -> STATIC if len<=6, else SCROLL. msg_load in any state re-enters.
//  - Latency: msg_load at edge N -> new chars, busy=1 visible after edge N+1. Tick counter
//    cleared on load; first step occurs exactly SCROLL_DIV cycles later.
//  - Display mapping: charK = msg[pos + (5-K)] if index < len, else 8'h20.
//  - STATIC: pos stays 0. On first tick: done pulses 1 cycle; stays in STATIC, chars held.
//  - SCROLL: each tick pos <= pos+1. On the tick where pos becomes len (all blank) the pass ends:
//    done pulses that cycle; behaviour after pass per CONFIGURATION.
//  - msg_load on same cycle as a tick: load wins, tick discarded, no done pulse.
//  - Chars never glitch between table entries: all six update on the same edge.
// CONFIGURATION
//  SCROLL_LOOP_EN defined: after a pass pos wraps to 0 and scrolling repeats indefinitely;
//    done pulses at the end of every pass; busy stays 1 until reset.
//  SCROLL_LOOP_EN undefined: after a pass pos returns to 0, first 6 chars shown, state -> STATIC
//    (hold, busy=1, no further done pulses) until next msg_load.
// STRUCTURE
//  - Shared include display_defs.vh: ASCII_BLANK=8'h20, ASCII_ZERO=8'h30, MSG_SELECT..MSG_CASH
//    IDs (3'd0..3'd7), state encodings ST_IDLE/ST_STATIC/ST_SCROLL.
//  - Sub-module message_rom: combinational; inputs msg_id[2:0], idx, price_bcd; outputs ascii[7:0]
//    (blank when idx >= len) and len. Six instances (one per digit) or one shared ROM function.
//  - Top: tick divider, pos counter, 3-state FSM, registered char outputs, done/busy logic.
// TESTING  (override CLK_HZ=8, SCROLL_HZ=2 -> SCROLL_DIV=4)
//  - Reset mid-scroll of msg 1 -> next sample char0..5=8'h20, busy=0, done=0 before clock edge.
//  - Load msg 0 -> one edge later char5..0 = "SELECT", busy=1; done pulses once 4 cycles later.
//  - Load msg 3 -> "THANK " then after 4 cycles "HANK Y"; pass ends 36 cycles after load with
//    all blanks + done pulse; then "THANK " held (loop off) / scroll restarts (loop on).
//  - Load msg 7, price_bcd=12'h150 -> "CASH 1", then scrolls to "ASH 15", "SH 150".
//  - price_bcd=12'h1A0 with msg 7 -> digit for A shown as 8'h20.
//  - msg_load of msg 2 coinciding with a scroll tick of msg 1 -> "PAID  " next edge, no done pulse.

Source files
------------

// File: rtl/message_scroller_pkg.sv
// Shared definitions for the message scroller: ASCII codes, message IDs, FSM states,
// and the fixed message table (text + length) used by the ROM and the top-level FSM.
// Purely declarative; no timing of its own.
package message_scroller_pkg;

  localparam logic [7:0] ASCII_BLANK = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  localparam logic [2:0] MSG_SELECT = 3'd0;
  localparam logic [2:0] MSG_INSERT = 3'd1;
  localparam logic [2:0] MSG_PAID   = 3'd2;
  localparam logic [2:0] MSG_THANKS = 3'd3;
  localparam logic [2:0] MSG_SOLD   = 3'd4;
  localparam logic [2:0] MSG_CANCEL = 3'd5;
  localparam logic [2:0] MSG_ERROR  = 3'd6;
  localparam logic [2:0] MSG_CASH   = 3'd7;

  // Text storage is right-aligned: the last character sits in bits [7:0].
  localparam int TEXT_CHARS = 16;
  localparam int TEXT_W     = 8 * TEXT_CHARS;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STATIC = 2'd1,
    ST_SCROLL = 2'd2
  } state_t;

  // One BCD digit as ASCII; non-decimal nibbles render as a blank.
  function automatic logic [7:0] bcd_ascii(input logic [3:0] d);
    return (d > 4'd9) ? ASCII_BLANK : (ASCII_ZERO + {4'h0, d});
  endfunction

  function automatic logic [4:0] msg_len(input logic [2:0] id);
    case (id)
      MSG_SELECT: return 5'd6;
      MSG_INSERT: return 5'd11;
      MSG_PAID:   return 5'd4;
      MSG_THANKS: return 5'd9;
      MSG_SOLD:   return 5'd8;
      MSG_CANCEL: return 5'd6;
      MSG_ERROR:  return 5'd5;
      default:    return 5'd8;
    endcase
  endfunction

  function automatic logic [TEXT_W-1:0] msg_text(input logic [2:0] id, input logic [11:0] price);
    logic [TEXT_W-1:0] t;
    t = '0;
    case (id)
      MSG_SELECT: t[47:0] = "SELECT";
      MSG_INSERT: t[87:0] = "INSERT COIN";
      MSG_PAID:   t[31:0] = "PAID";
      MSG_THANKS: t[71:0] = "THANK YOU";
      MSG_SOLD:   t[63:0] = "SOLD OUT";
      MSG_CANCEL: t[47:0] = "CANCEL";
      MSG_ERROR:  t[39:0] = "ERROR";
      default:    t[63:0] = {"CASH ", bcd_ascii(price[11:8]), bcd_ascii(price[7:4]),
                             bcd_ascii(price[3:0])};
    endcase
    return t;
  endfunction

endpackage

// File: rtl/message_rom.sv
// Purpose: one display character of the message table at a given character index.
// Latency: purely combinational.
// Backpressure: none; output follows inputs, blank beyond the end of the message.
module message_rom
  import message_scroller_pkg::*;
#(
  parameter int IDX_W = 5,
  parameter int LEN_W = 5
) (
  input  logic [2:0]       msg_id,
  input  logic [IDX_W-1:0] idx,
  input  logic [11:0]      price_bcd,
  output logic [7:0]       ascii,
  output logic [LEN_W-1:0] len
);

  localparam int BASE_W = $clog2(TEXT_W);

  logic [TEXT_W-1:0] text;
  logic [4:0]        raw_len;
  logic [BASE_W-1:0] base;

  // Table lookup: message text and length depend only on the message ID (and price).
  always_comb begin
    raw_len = msg_len(msg_id);
    text    = msg_text(msg_id, price_bcd);
  end

  assign len = LEN_W'(raw_len);

  // Pick character idx counted from the left; anything past the end shows blank.
  always_comb begin
    ascii = ASCII_BLANK;
    base  = '0;
    if (int'(idx) < int'(raw_len)) begin
      base  = BASE_W'((int'(raw_len) - 1 - int'(idx)) * 8);
      ascii = text[base +: 8];
    end
  end

endmodule

// File: rtl/message_scroller.sv
// Purpose: drives six ASCII digits from the message table, static or scrolling left.
// Latency: msg_load sampled on an edge updates chars/busy on that same edge; steps every SCROLL_DIV cycles.
// Backpressure: none; msg_load is always accepted and restarts the display. Build option: SCROLL_LOOP_EN.
module message_scroller
  import message_scroller_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int SCROLL_HZ = 4,
  parameter int MAX_LEN   = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  msg_sel,
  input  logic        msg_load,
  input  logic [11:0] price_bcd,
  output logic [7:0]  char0,
  output logic [7:0]  char1,
  output logic [7:0]  char2,
  output logic [7:0]  char3,
  output logic [7:0]  char4,
  output logic [7:0]  char5,
  output logic        busy,
  output logic        done
);

  localparam int SCROLL_DIV = CLK_HZ / SCROLL_HZ;
  localparam int CNT_W      = $clog2(SCROLL_DIV);
  localparam int POS_W      = $clog2(MAX_LEN + 1);
  localparam int IDX_W      = $clog2(MAX_LEN + 6);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCROLL_DIV - 1);

  state_t           state_q, state_n;
  logic [2:0]       msg_q, msg_n;
  logic [11:0]      price_q, price_n;
  logic [POS_W-1:0] pos_q, pos_n, pos_inc, len_q;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             pending_q, pending_n;
  logic             done_n, tick;
  logic [7:0]       chars_q   [6];
  logic [7:0]       rom_ascii [6];
  logic [POS_W-1:0] rom_len   [6];

  assign tick    = (state_q != ST_IDLE) && (cnt_q == CNT_LAST);
  assign pos_inc = pos_q + POS_W'(1);

  // Next-state logic: a load always wins over a coincident tick and suppresses done.
  always_comb begin
    state_n   = state_q;
    msg_n     = msg_q;
    price_n   = price_q;
    pos_n     = pos_q;
    pending_n = pending_q;
    done_n    = 1'b0;
    cnt_n     = (state_q == ST_IDLE || tick) ? '0 : cnt_q + CNT_W'(1);
    if (msg_load) begin
      msg_n     = msg_sel;
      price_n   = price_bcd;
      pos_n     = '0;
      cnt_n     = '0;
      pending_n = 1'b1;
      state_n   = (msg_len(msg_sel) <= 5'd6) ? ST_STATIC : ST_SCROLL;
    end else begin
      case (state_q)
        ST_STATIC: begin
          // Only the first tick after a load reports completion.
          if (tick && pending_q) begin
            done_n    = 1'b1;
            pending_n = 1'b0;
          end
        end
        ST_SCROLL: begin
          if (tick) begin
            if (pos_q == len_q) begin
              // Blank frame has been shown for one step; restart from the left.
              pos_n = '0;
`ifdef SCROLL_LOOP_EN
              state_n = ST_SCROLL;
`else
              state_n   = ST_STATIC;
              pending_n = 1'b0;
`endif
            end else begin
              pos_n  = pos_inc;
              done_n = (pos_inc == len_q);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // One ROM lookup per digit so all six characters come from the same next-state view.
  for (genvar k = 0; k < 6; k++) begin : g_digit
    message_rom #(
      .IDX_W(IDX_W),
      .LEN_W(POS_W)
    ) u_rom (
      .msg_id   (msg_n),
      .idx      (IDX_W'(pos_n) + IDX_W'(5 - k)),
      .price_bcd(price_n),
      .ascii    (rom_ascii[k]),
      .len      (rom_len[k])
    );
  end

  // State, counters and registered outputs; chars stay blank until the first load.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      msg_q     <= MSG_SELECT;
      price_q   <= '0;
      pos_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      done      <= 1'b0;
      for (int k = 0; k < 6; k++) chars_q[k] <= ASCII_BLANK;
    end else begin
      state_q   <= state_n;
      msg_q     <= msg_n;
      price_q   <= price_n;
      pos_q     <= pos_n;
      cnt_q     <= cnt_n;
      pending_q <= pending_n;
      done      <= done_n;
      if (msg_load) len_q <= rom_len[0];
      for (int k = 0; k < 6; k++)
        chars_q[k] <= (state_n == ST_IDLE) ? ASCII_BLANK : rom_ascii[k];
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign char0 = chars_q[0];
  assign char1 = chars_q[1];
  assign char2 = chars_q[2];
  assign char3 = chars_q[3];
  assign char4 = chars_q[4];
  assign char5 = chars_q[5];

endmodule

// File: tb/tb_message_scroller.sv
// Directed bench for message_scroller with CLK_HZ=8, SCROLL_HZ=2 (four cycles per scroll step).
// Outputs are sampled 1 time unit after each rising edge; inputs change at that same point.
module tb_message_scroller;

  logic        clock;
  logic        reset_n;
  logic [2:0]  msg_sel;
  logic        msg_load;
  logic [11:0] price_bcd;
  logic [7:0]  char0, char1, char2, char3, char4, char5;
  logic        busy, done;
  logic [47:0] shown;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;

  message_scroller #(
    .CLK_HZ   (8),
    .SCROLL_HZ(2),
    .MAX_LEN  (16)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .msg_sel  (msg_sel),
    .msg_load (msg_load),
    .price_bcd(price_bcd),
    .char0    (char0),
    .char1    (char1),
    .char2    (char2),
    .char3    (char3),
    .char4    (char4),
    .char5    (char5),
    .busy     (busy),
    .done     (done)
  );

  assign shown = {char5, char4, char3, char2, char1, char0};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance n edges, counting done pulses seen after each edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      if (done === 1'b1) pulses++;
    end
  endtask

  task automatic load(input logic [2:0] id, input logic [11:0] p);
    msg_sel   = id;
    price_bcd = p;
    msg_load  = 1'b1;
    @(posedge clock);
    #1;
    msg_load  = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n   = 1'b1;
    msg_sel   = 3'd0;
    msg_load  = 1'b0;
    price_bcd = 12'h000;
    #3 reset_n = 1'b0;
    step(2);
    chk("rst_chars", shown, "      ");
    chk("rst_busy", {47'b0, busy}, 48'd0);
    chk("rst_done", {47'b0, done}, 48'd0);
    reset_n = 1'b1;
    step(2);
    chk("idle_chars", shown, "      ");

    // Static message: shown after the load edge, done four cycles later, exactly once.
    load(3'd0, 12'h000);
    chk("sel_chars", shown, "SELECT");
    chk("sel_busy", {47'b0, busy}, 48'd1);
    pulses = 0;
    step(3);
    chk("sel_early_done", 48'(pulses), 48'd0);
    step(1);
    chk("sel_done", {47'b0, done}, 48'd1);
    pulses = 0;
    step(8);
    chk("sel_one_pulse", 48'(pulses), 48'd0);
    chk("sel_hold", shown, "SELECT");

    // Scrolling message of 9 chars: one step per four cycles, pass ends 36 cycles after load.
    load(3'd3, 12'h000);
    chk("thk_chars0", shown, "THANK ");
    step(4);
    chk("thk_chars1", shown, "HANK Y");
    step(4);
    chk("thk_chars2", shown, "ANK YO");
    pulses = 0;
    step(27);
    chk("thk_chars8", shown, "U     ");
    chk("thk_no_early_done", 48'(pulses), 48'd0);
    step(1);
    chk("thk_blank", shown, "      ");
    chk("thk_done", {47'b0, done}, 48'd1);
    step(4);
    chk("thk_restart", shown, "THANK ");
    chk("thk_busy", {47'b0, busy}, 48'd1);
    pulses = 0;
    step(4);
`ifdef SCROLL_LOOP_EN
    chk("thk_loop", shown, "HANK Y");
    step(32);
    chk("thk_loop_done", {47'b0, done}, 48'd1);
`else
    chk("thk_held", shown, "THANK ");
    step(32);
    chk("thk_no_more_done", 48'(pulses), 48'd0);
`endif

    // Price message with valid BCD digits.
    load(3'd7, 12'h150);
    chk("cash_chars0", shown, "CASH 1");
    step(4);
    chk("cash_chars1", shown, "ASH 15");
    step(4);
    chk("cash_chars2", shown, "SH 150");

    // Non-decimal nibble renders blank.
    load(3'd7, 12'h1A0);
    chk("cashA_chars0", shown, "CASH 1");
    step(8);
    chk("cashA_chars2", shown, "SH 1 0");
    chk("cashA_char1", {40'b0, char1}, 48'h20);

    // Load landing on a scroll tick: load wins, no done.
    load(3'd1, 12'h000);
    chk("ins_chars0", shown, "INSERT");
    step(3);
    msg_sel  = 3'd2;
    msg_load = 1'b1;
    @(posedge clock);
    #1;
    msg_load = 1'b0;
    chk("paid_chars", shown, "PAID  ");
    chk("paid_no_done", {47'b0, done}, 48'd0);
    pulses = 0;
    step(3);
    chk("paid_early", 48'(pulses), 48'd0);
    step(1);
    chk("paid_done", {47'b0, done}, 48'd1);

    // Asynchronous reset in the middle of a scroll.
    load(3'd1, 12'h000);
    step(4);
    chk("ins_chars1", shown, "NSERT ");
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_chars", shown, "      ");
    chk("mid_rst_busy", {47'b0, busy}, 48'd0);
    chk("mid_rst_done", {47'b0, done}, 48'd0);
    pulses = 0;
    step(2);
    chk("mid_rst_hold_done", 48'(pulses), 48'd0);
    reset_n = 1'b1;
    step(6);
    chk("post_rst_busy", {47'b0, busy}, 48'd0);
    chk("post_rst_chars", shown, "      ");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
